// File: rtl/canvas_painter.sv
// 1-bit-per-cell canvas store for the drawing path, serving a registered
// 12-bit VGA colour with a cursor overlay and a reset/on-demand clear sweep.
module canvas_painter #(
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          CELL_SHIFT = 2,
    parameter logic [11:0] INK_RGB    = 12'h000,
    parameter logic [11:0] BG_RGB     = 12'hFFF,
    parameter logic [11:0] CURSOR_RGB = 12'hF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  mouseX,
    input  logic [9:0]  mouseY,
    input  logic        pixel_will_painted,
    input  logic        clear_req,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    output logic [11:0] rgb,
    output logic        busy
);

    localparam int CW    = SCREEN_W >> CELL_SHIFT;
    localparam int CH    = SCREEN_H >> CELL_SHIFT;
    localparam int DEPTH = CW * CH;
    localparam int AW    = 15;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // Scan attributes carried alongside the RAM read stage
    typedef struct packed {
        logic vis;
        logic hit;
        logic busy;
    } scan_t;

    // Row stride of 160 cells folded into two shifts
    function automatic logic [AW-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
        logic [AW-1:0] cx;
        logic [AW-1:0] cy;
        cx = AW'(x >> CELL_SHIFT);
        cy = AW'(y >> CELL_SHIFT);
        return (cy << 7) + (cy << 5) + cx;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic            w_wdata;
    logic            w_mouse_in;
    logic            w_scan_vis;
    logic            w_hit;
    logic [AW-1:0]   w_raddr;
    logic            r_mem [0:DEPTH-1];
    logic            r_rd_bit;
    scan_t           r_s1;
    logic [11:0]     r_rgb;

    assign w_mouse_in = (mouseX < 10'(SCREEN_W)) && (mouseY < 10'(SCREEN_H));
    assign w_scan_vis = video_on && (hcount < 10'(SCREEN_W)) && (vcount < 10'(SCREEN_H));
    assign w_hit      = ((hcount >> CELL_SHIFT) == (mouseX >> CELL_SHIFT)) &&
                        ((vcount >> CELL_SHIFT) == (mouseY >> CELL_SHIFT));
    assign w_raddr    = w_scan_vis ? cell_addr(hcount, vcount) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_CLEAR;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
            ST_RUN:   if (clear_req)              w_state_nxt = ST_CLEAR;
            default:                              w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_clr_cnt;
            end
            ST_RUN: begin
                if (!clear_req && pixel_will_painted && w_mouse_in) begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(mouseX, mouseY);
                    w_wdata = 1'b1;
                end
            end
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 r_clr_cnt <= '0;
        else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
        else if (clear_req)           r_clr_cnt <= '0;
    end

    // Write and read on the same edge: a colliding read sees the old bit
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_bit <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_rd_bit  <= r_mem[w_raddr];
            r_s1.vis  <= w_scan_vis;
            r_s1.hit  <= w_hit;
            r_s1.busy <= busy;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_rgb <= 12'h000;
        else if (!r_s1.vis) r_rgb <= 12'h000;
        else if (r_s1.hit)  r_rgb <= CURSOR_RGB;
        else if (r_s1.busy) r_rgb <= BG_RGB;
        else if (r_rd_bit)  r_rgb <= INK_RGB;
        else                r_rgb <= BG_RGB;
    end

    assign rgb = r_rgb;

endmodule

// File: tb/tb_canvas_painter.sv
// Directed bench for canvas_painter: sweep timing, paint, overlay, clear, reset.
module tb_canvas_painter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  mouseX, mouseY, hcount, vcount;
    logic        paint, clear_req, video_on;
    logic [11:0] rgb;
    logic        busy;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    canvas_painter dut (
        .clk(clk), .reset_n(reset_n), .mouseX(mouseX), .mouseY(mouseY),
        .pixel_will_painted(paint), .clear_req(clear_req),
        .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .rgb(rgb), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input string tag, input int h, input int v, input logic vo,
                        input logic [11:0] exp);
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); video_on = vo;
        @(posedge clk); @(posedge clk); #1;
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic set_mouse(input int x, input int y);
        @(negedge clk);
        mouseX = 10'(x); mouseY = 10'(y);
    endtask

    task automatic paint_at(input int x, input int y, input int cycles);
        @(negedge clk);
        mouseX = 10'(x); mouseY = 10'(y); paint = 1'b1;
        repeat (cycles) @(negedge clk);
        paint = 1'b0;
    endtask

    // Counts edges until busy drops; optional clear_req pulse mid-sweep
    task automatic sweep_len(input string tag, input bit pulse);
        int n = 0;
        while (busy === 1'b1 && n < 20000) begin
            @(posedge clk); #1;
            n++;
            clear_req = (pulse && n == 100);
        end
        clear_req = 1'b0;
        paint = 1'b0;
        chk(tag, 32'(n), 32'd19200);
    endtask

    // Pipelined scan of every 7th cell; all must show background
    task automatic bg_scan(input string tag);
        int bad = 0;
        int nc = 19200 / 7 + 1;
        for (int k = 0; k <= nc; k++) begin
            @(negedge clk);
            if (k < nc) begin
                hcount = 10'(((k * 7) % 160) * 4 + 1);
                vcount = 10'(((k * 7) / 160) * 4 + 2);
                video_on = 1'b1;
            end
            @(posedge clk); #1;
            if (k >= 2 && rgb !== 12'hFFF) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        mouseX = 10'd600; mouseY = 10'd400; paint = 1'b0; clear_req = 1'b0;
        hcount = 10'd0; vcount = 10'd0; video_on = 1'b1;
        #1;
        chk("reset_rgb", 32'(rgb), 32'h000);
        chk("reset_busy", 32'(busy), 32'd1);

        @(negedge clk); reset_n = 1'b1;
        sweep_len("init_sweep_len", 1'b0);
        scan("bg_00", 0, 0, 1'b1, 12'hFFF);

        paint_at(320, 239, 1);
        set_mouse(0, 0);
        scan("ink_321_238", 321, 238, 1'b1, 12'h000);
        scan("bg_324_238", 324, 238, 1'b1, 12'hFFF);
        scan("ink_320_236", 320, 236, 1'b1, 12'h000);

        set_mouse(3, 3);
        scan("cursor_2_1", 2, 1, 1'b1, 12'hF00);
        scan("cursor_vo0", 2, 1, 1'b0, 12'h000);
        set_mouse(321, 237);
        scan("cursor_over_ink", 320, 236, 1'b1, 12'hF00);

        set_mouse(600, 100);
        scan("edge_639_479", 639, 479, 1'b1, 12'hFFF);
        scan("h_out_640", 640, 10, 1'b1, 12'h000);
        scan("v_out_480", 10, 480, 1'b1, 12'h000);

        paint_at(0, 0, 1);
        paint_at(636, 476, 1);
        set_mouse(600, 100);
        scan("ink_cell_0_0", 1, 1, 1'b1, 12'h000);
        scan("ink_cell_159_119", 637, 477, 1'b1, 12'h000);

        // clear_req together with paint: clear wins, then paint held through sweep
        @(negedge clk);
        mouseX = 10'd40; mouseY = 10'd40; paint = 1'b1; clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        mouseX = 10'd44; mouseY = 10'd44;
        chk("clear_busy_rise", 32'(busy), 32'd1);
        sweep_len("clear_sweep_len", 1'b1);
        set_mouse(600, 100);
        scan("cleared_0_0", 1, 1, 1'b1, 12'hFFF);
        scan("cleared_159_119", 637, 477, 1'b1, 12'hFFF);
        scan("cleared_10_10", 41, 41, 1'b1, 12'hFFF);
        scan("no_paint_in_sweep", 45, 45, 1'b1, 12'hFFF);
        scan("cleared_80_59", 321, 238, 1'b1, 12'hFFF);

        paint_at(700, 300, 10);
        paint_at(100, 500, 10);
        set_mouse(700, 300);
        scan("oor_alias_cell", 60, 304, 1'b1, 12'hFFF);
        bg_scan("oor_canvas_bg");

        scan("pre_reset_bg", 8, 8, 1'b1, 12'hFFF);
        @(negedge clk); clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        repeat (5000) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_rgb", 32'(rgb), 32'h000);
        chk("midreset_busy", 32'(busy), 32'd1);
        @(negedge clk); reset_n = 1'b1;
        sweep_len("resweep_len", 1'b0);
        scan("post_reset_bg", 8, 8, 1'b1, 12'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
